// File: rtl/prio_rr_encoder_if.sv
// Request/grant bundle between the request sources, the encoder and the
// downstream consumer.
interface prio_rr_encoder_if #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) ();
    logic [N-1:0] req;
    logic         mode;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] grant_idx;
    logic [N-1:0] grant_oh;

    modport master (
        output req, mode, out_ready,
        input  out_valid, grant_idx, grant_oh
    );

    modport slave (
        input  req, mode, out_ready,
        output out_valid, grant_idx, grant_oh
    );
endinterface

// File: rtl/prio_rr_encoder.sv
// N-input priority encoder, fixed or round-robin, with a registered
// grant (index + one-hot) behind a valid/ready output handshake.
module prio_rr_encoder #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input logic               clk,
    input logic               rst,
    prio_rr_encoder_if.slave  bus
);

    logic [W-1:0] ptr;
    logic [W-1:0] ptr_next;
    logic         accept;
    logic         load;
    logic [W-1:0] win_p0;
    logic         any_p0;

    // Highest-index set bit wins.
    function automatic logic [W-1:0] fixed_pick(input logic [N-1:0] r);
        logic [W-1:0] win;
        win = '0;
        for (int i = 0; i < N; i++) begin
            if (r[i]) win = W'(i);
        end
        return win;
    endfunction

    // Descending search from start, wrapping below 0 back to N-1.
    function automatic logic [W-1:0] rr_pick(input logic [N-1:0] r,
                                             input logic [W-1:0] start);
        logic [W-1:0] win;
        logic         found;
        int           idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(start) - k;
            if (idx < 0) idx = idx + N;
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = W'(idx);
            end
        end
        return win;
    endfunction

    assign accept = bus.out_valid & bus.out_ready;
    assign load   = ~bus.out_valid | bus.out_ready;

    always_comb begin
        ptr_next = ptr;
        if (accept) begin
            ptr_next = (bus.grant_idx == '0) ? W'(N - 1) : bus.grant_idx - W'(1);
        end
    end

    // Round-robin search starts at ptr_next so an accept and the following
    // reload share one cycle without a bubble.
    always_comb begin
        any_p0 = |bus.req;
        win_p0 = bus.mode ? rr_pick(bus.req, ptr_next) : fixed_pick(bus.req);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr           <= W'(N - 1);
            bus.out_valid <= 1'b0;
            bus.grant_idx <= '0;
            bus.grant_oh  <= '0;
        end else begin
            ptr <= ptr_next;
            if (load) begin
                bus.out_valid <= any_p0;
                bus.grant_idx <= any_p0 ? win_p0 : '0;
                bus.grant_oh  <= any_p0 ? (N'(1) << win_p0) : '0;
            end
        end
    end

endmodule

// File: tb/tb_prio_rr_encoder.sv
// Directed bench for prio_rr_encoder (N = 8): vector table plus reset and
// asynchronous-clear sequences.
module tb_prio_rr_encoder;

    localparam int N = 8;
    localparam int W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    prio_rr_encoder_if #(.N(N), .W(W)) bus ();

    prio_rr_encoder #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [N-1:0] req;
        logic         mode;
        logic         rdy;
        logic         v;
        logic [W-1:0] idx;
        logic [N-1:0] oh;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [N-1:0] req, input logic mode,
                                input logic rdy, input logic v,
                                input logic [W-1:0] idx, input logic [N-1:0] oh);
        vec_t t;
        t.req = req; t.mode = mode; t.rdy = rdy;
        t.v = v; t.idx = idx; t.oh = oh;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {19'd0, bus.out_valid, bus.grant_idx, bus.grant_oh};
    endfunction

    function automatic logic [31:0] pack_exp(input logic v, input logic [W-1:0] idx,
                                             input logic [N-1:0] oh);
        return {19'd0, v, idx, oh};
    endfunction

    initial begin
        // Fixed-priority encode, then idle
        tbl.push_back(mk(8'b0010_1100, 0, 1, 1, 3'd5, 8'h20));
        tbl.push_back(mk(8'h00,        0, 1, 0, 3'd0, 8'h00));
        // Stall hold while req changes, then release
        tbl.push_back(mk(8'b0010_1100, 0, 1, 1, 3'd5, 8'h20));
        tbl.push_back(mk(8'h01,        0, 0, 1, 3'd5, 8'h20));
        tbl.push_back(mk(8'h01,        0, 0, 1, 3'd5, 8'h20));
        tbl.push_back(mk(8'h01,        0, 0, 1, 3'd5, 8'h20));
        tbl.push_back(mk(8'h01,        0, 1, 1, 3'd0, 8'h01));
        tbl.push_back(mk(8'h00,        0, 1, 0, 3'd0, 8'h00));
        // Round-robin rotation with all requests active
        for (int i = 7; i >= 0; i--)
            tbl.push_back(mk(8'hFF, 1, 1, 1, W'(i), N'(1) << i));
        tbl.push_back(mk(8'hFF, 1, 1, 1, 3'd7, 8'h80));
        // Fairness: round-robin alternates, fixed sticks to 7
        tbl.push_back(mk(8'h00, 1, 1, 0, 3'd0, 8'h00));
        tbl.push_back(mk(8'h01, 1, 1, 1, 3'd0, 8'h01));
        tbl.push_back(mk(8'h81, 1, 1, 1, 3'd7, 8'h80));
        tbl.push_back(mk(8'h81, 1, 1, 1, 3'd0, 8'h01));
        tbl.push_back(mk(8'h81, 1, 1, 1, 3'd7, 8'h80));
        tbl.push_back(mk(8'h81, 1, 1, 1, 3'd0, 8'h01));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(8'h81, 0, 1, 1, 3'd7, 8'h80));
        // Sparse requests with wrap-around search, then mode switch
        tbl.push_back(mk(8'h10,        1, 1, 1, 3'd4, 8'h10));
        tbl.push_back(mk(8'b0011_0000, 1, 1, 1, 3'd5, 8'h20));
        tbl.push_back(mk(8'b0011_0000, 0, 1, 1, 3'd5, 8'h20));

        bus.req = '0;
        bus.mode = 1'b0;
        bus.out_ready = 1'b1;

        // Reset held over two edges
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", outs(), pack_exp(0, 0, 0));
        check("reset_ptr", 32'(dut.ptr), 32'd7);
        rst = 1'b0;

        foreach (tbl[i]) begin
            bus.req = tbl[i].req;
            bus.mode = tbl[i].mode;
            bus.out_ready = tbl[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), outs(), pack_exp(tbl[i].v, tbl[i].idx, tbl[i].oh));
        end

        // Asynchronous clear while a grant is stalled
        bus.req = 8'b0010_1100;
        bus.mode = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("pre_async_hold", outs(), pack_exp(1, 3'd5, 8'h20));
        #3;
        rst = 1'b1;
        #1;
        check("async_clear_outputs", outs(), pack_exp(0, 0, 0));
        check("async_clear_ptr", 32'(dut.ptr), 32'd7);
        #2;
        rst = 1'b0;
        #1;
        check("post_release_no_grant", outs(), pack_exp(0, 0, 0));
        @(posedge clk);
        #1;
        check("first_grant_after_reset", outs(), pack_exp(1, 3'd5, 8'h20));

        // After reset, round-robin first grant matches fixed priority
        rst = 1'b1;
        #1;
        rst = 1'b0;
        bus.req = 8'b0110_0010;
        bus.mode = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rr_first_like_fixed", outs(), pack_exp(1, 3'd6, 8'h40));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
